misc_issue_queue: RTL
=====================

# misc_issue_queue

In-order issue queue and scheduler in front of the misc execution pipe (branch, CSR, TLB, cache-op instructions). It buffers up to DEPTH dispatched misc micro-ops and tracks operand readiness through physical-register wakeups. It presents exactly one micro-op at a time, the oldest, to the misc pipe through a valid/ready handshake. Privileged ops are held until they reach the ROB head, so their side effects are never speculative.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- PAYLOAD_W, 128, opaque micro-op payload width, passed through unchanged
- PREG_W, 6, physical register index width
- ROB_IDX_W, 6, ROB index width
- WAKE_N, 2, number of wakeup ports

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  queue can accept a micro-op
- disp_payload_i  in  PAYLOAD_W  micro-op body
- disp_rob_idx_i  in  ROB_IDX_W  ROB index of the micro-op
- disp_priv_i  in  1  privileged op; requires ROB head before issue
- disp_psrc0_i, disp_psrc1_i  in  PREG_W each  source physical registers
- disp_rdy0_i, disp_rdy1_i  in  1 each  source already ready at dispatch
- wake_valid_i  in  WAKE_N  wakeup strobes
- wake_preg_i  in  WAKE_N*PREG_W  woken registers, port k at bits [k*PREG_W +: PREG_W]
- rob_head_idx_i  in  ROB_IDX_W  current ROB head
- issue_valid_o  out  1  head micro-op issuable
- issue_ready_i  in  1  misc pipe accepts
- issue_payload_o  out  PAYLOAD_W  head payload
- issue_rob_idx_o  out  ROB_IDX_W  head ROB index

## Operation
- Storage is a circular buffer. Pointers are head/tail with log2(DEPTH) bits each, wrapping modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Each entry holds: valid, payload, rob_idx, priv, psrc0/1, rdy0/1.
- Dispatch fires when disp_valid_i & disp_ready_o. It writes the tail entry and increments tail and count.
- disp_ready_o = (count != DEPTH). It is computed from registered state only, so an issue in the same cycle does not free a slot for dispatch when full.
- Wakeup: for every valid entry and each port k with wake_valid_i[k], set rdyN when psrcN == wake_preg_i[k].
  - This also applies to the entry being dispatched in the same cycle, so no wakeup is ever lost.
- Issue condition for the head entry: valid & rdy0 & rdy1 & (~priv | rob_idx == rob_head_idx_i).
- issue_valid_o equals the issue condition. Payload and rob_idx outputs come from the head entry.
- An issue fires when issue_valid_o & issue_ready_i. It clears the head entry and increments head. Count decrements.
- Simultaneous dispatch and issue: count is unchanged, both pointers advance.
- Entries younger than a blocked head never issue; ordering is strict.
- flush_i clears every valid bit and resets head, tail and count to 0. It has priority over dispatch, issue and wakeup in the same cycle.
- Reset values: all entries invalid, pointers and count 0. Outputs: disp_ready_o=1, issue_valid_o=0, issue_payload_o=0, issue_rob_idx_o=0.
  - Payload and rob_idx storage are reset to 0 so the outputs are defined.

## Timing
- Dispatch to earliest issue: 1 cycle (entry visible at head the cycle after the write).
- Without the bypass option, a wakeup raises issue_valid_o one cycle later.
- Throughput: one issue per cycle when the pipe is ready and operands are ready.
- issue_valid_o stays stable until accepted, except when flush_i drops it.
- Payload and rob_idx are held while valid & ~ready.
- Reset asserted mid-operation empties the queue immediately (asynchronous), with no partial issue.

## Configuration
- MISC_IQ_WAKE_BYPASS_EN defined: the head issue condition also ORs in the current-cycle wakeup matches for psrc0/psrc1. A head waiting on one register issues in the same cycle its wakeup arrives. This is a combinational path wake_* -> issue_valid_o.
- Not defined: the issue condition uses registered rdy bits only, and wakeup-to-issue latency is 1 cycle.
- Register updates are identical in both cases.

## Test plan
- Dispatch 4 ops with all sources ready, issue_ready_i=1 -> issued in order on cycles 1-4, disp_ready_o=1 throughout.
- Fill the queue (DEPTH=4), issue_ready_i=0 -> disp_ready_o=0 and the 5th dispatch is refused. Hold issue_ready_i=1 for one cycle -> one entry leaves and disp_ready_o=1 the next cycle. Pointer wrap is exercised.
- Head with psrc0=7 not ready, wake_preg=7 asserted at cycle N -> issue_valid_o at N+1 (without macro) or N (with macro). A younger ready op does not issue before the head.
- Wakeup of preg 9 in the same cycle as dispatch of an op with psrc1=9, rdy1=0 -> op issues the next cycle.
- Priv op rob_idx=5, rob_head_idx_i=3 -> issue_valid_o=0. rob_head_idx_i changes to 5 -> issue_valid_o=1 the same cycle.
- Queue holding 3 entries, flush_i coinciding with dispatch and issue -> count=0, issue_valid_o=0, disp_ready_o=1 the next cycle, and the dispatched op is discarded.

Source files
------------

// File: rtl/misc_issue_queue.sv
// In-order issue queue for the misc execution pipe: circular buffer with operand wakeup and ROB-head gating for privileged ops.
// Optional same-cycle wakeup bypass into the head issue condition: define MISC_IQ_WAKE_BYPASS_EN.
module misc_issue_queue #(
   parameter int DEPTH     = 4,
   parameter int PAYLOAD_W = 128,
   parameter int PREG_W    = 6,
   parameter int ROB_IDX_W = 6,
   parameter int WAKE_N    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     disp_valid_i,
   output logic                     disp_ready_o,
   input  logic [PAYLOAD_W-1:0]     disp_payload_i,
   input  logic [ROB_IDX_W-1:0]     disp_rob_idx_i,
   input  logic                     disp_priv_i,
   input  logic [PREG_W-1:0]        disp_psrc0_i,
   input  logic [PREG_W-1:0]        disp_psrc1_i,
   input  logic                     disp_rdy0_i,
   input  logic                     disp_rdy1_i,
   input  logic [WAKE_N-1:0]        wake_valid_i,
   input  logic [WAKE_N*PREG_W-1:0] wake_preg_i,
   input  logic [ROB_IDX_W-1:0]     rob_head_idx_i,
   output logic                     issue_valid_o,
   input  logic                     issue_ready_i,
   output logic [PAYLOAD_W-1:0]     issue_payload_o,
   output logic [ROB_IDX_W-1:0]     issue_rob_idx_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   logic                 ent_valid   [DEPTH];
   logic [PAYLOAD_W-1:0] ent_payload [DEPTH];
   logic [ROB_IDX_W-1:0] ent_rob_idx [DEPTH];
   logic                 ent_priv    [DEPTH];
   logic [PREG_W-1:0]    ent_psrc0   [DEPTH];
   logic [PREG_W-1:0]    ent_psrc1   [DEPTH];
   logic                 ent_rdy0    [DEPTH];
   logic                 ent_rdy1    [DEPTH];

   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W:0]   count;

   logic disp_fire;
   logic issue_fire;
   logic head_byp0;
   logic head_byp1;
   logic head_rdy0;
   logic head_rdy1;

   function automatic logic wake_hit(input logic [PREG_W-1:0]        preg,
                                     input logic [WAKE_N-1:0]        vld,
                                     input logic [WAKE_N*PREG_W-1:0] pregs);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < WAKE_N; k++) begin
         if (vld[k] && (pregs[k*PREG_W +: PREG_W] == preg)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Ready is taken from registered occupancy only, so a full queue stays full during an issue.
   assign disp_ready_o = (count != FULL_CNT);
   assign disp_fire    = disp_valid_i & disp_ready_o;

`ifdef MISC_IQ_WAKE_BYPASS_EN
   assign head_byp0 = wake_hit(ent_psrc0[head_ptr], wake_valid_i, wake_preg_i);
   assign head_byp1 = wake_hit(ent_psrc1[head_ptr], wake_valid_i, wake_preg_i);
`else
   assign head_byp0 = 1'b0;
   assign head_byp1 = 1'b0;
`endif

   assign head_rdy0 = ent_rdy0[head_ptr] | head_byp0;
   assign head_rdy1 = ent_rdy1[head_ptr] | head_byp1;

   assign issue_valid_o   = ent_valid[head_ptr] & head_rdy0 & head_rdy1 &
                            (~ent_priv[head_ptr] | (ent_rob_idx[head_ptr] == rob_head_idx_i));
   assign issue_fire      = issue_valid_o & issue_ready_i;
   assign issue_payload_o = ent_payload[head_ptr];
   assign issue_rob_idx_o = ent_rob_idx[head_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i]   <= 1'b0;
            ent_payload[i] <= '0;
            ent_rob_idx[i] <= '0;
            ent_priv[i]    <= 1'b0;
            ent_psrc0[i]   <= '0;
            ent_psrc1[i]   <= '0;
            ent_rdy0[i]    <= 1'b0;
            ent_rdy1[i]    <= 1'b0;
         end
      end else if (flush_i) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) ent_valid[i] <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
               if (wake_hit(ent_psrc0[i], wake_valid_i, wake_preg_i)) ent_rdy0[i] <= 1'b1;
               if (wake_hit(ent_psrc1[i], wake_valid_i, wake_preg_i)) ent_rdy1[i] <= 1'b1;
            end
            // The incoming op also sees this cycle's wakeups so none are lost.
            if (disp_fire && (tail_ptr == PTR_W'(i))) begin
               ent_valid[i]   <= 1'b1;
               ent_payload[i] <= disp_payload_i;
               ent_rob_idx[i] <= disp_rob_idx_i;
               ent_priv[i]    <= disp_priv_i;
               ent_psrc0[i]   <= disp_psrc0_i;
               ent_psrc1[i]   <= disp_psrc1_i;
               ent_rdy0[i]    <= disp_rdy0_i | wake_hit(disp_psrc0_i, wake_valid_i, wake_preg_i);
               ent_rdy1[i]    <= disp_rdy1_i | wake_hit(disp_psrc1_i, wake_valid_i, wake_preg_i);
            end
            if (issue_fire && (head_ptr == PTR_W'(i))) ent_valid[i] <= 1'b0;
         end
         if (disp_fire)  tail_ptr <= tail_ptr + 1'b1;
         if (issue_fire) head_ptr <= head_ptr + 1'b1;
         case ({disp_fire, issue_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
